// File: rtl/cnu_minsum_seq.sv
// Serial min-sum check-node sequencer.
// Collects DEG two's-complement V2C LLRs, tracks min1/min2/idx1/sign parity,
// then emits DEG C2V LLRs in two's complement with a valid/ready handshake.
// Optional macro CNU_OFFSET_EN: offset min-sum (magnitudes reduced by BETA, floored at 0).
module cnu_minsum_seq #(
    parameter int unsigned W    = 10,
    parameter int unsigned DEG  = 6,
    parameter int unsigned BETA = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_llr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_llr,
    output logic         out_last,
    output logic         busy
);

    localparam int unsigned MW = W - 1;
    localparam int unsigned CW = $clog2(DEG);
    localparam logic [MW-1:0] MagMax = {MW{1'b1}};

    // Elaboration-time sanity checks on the configuration
    if (DEG < 2) begin : g_bad_deg
        $error("cnu_minsum_seq: DEG must be >= 2");
    end
    if (BETA > MagMax) begin : g_bad_beta
        $error("cnu_minsum_seq: BETA exceeds the magnitude range");
    end

    typedef enum logic [0:0] {StCollect, StEmit} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [MW-1:0]   min1_q, min1_d;
    logic [MW-1:0]   min2_q, min2_d;
    logic [CW-1:0]   idx1_q, idx1_d;
    logic [DEG-1:0]  signs_q, signs_d;
    logic            parity_q, parity_d;

    logic            emit;
    logic            accept;
    logic            cnt_last;
    logic [W-1:0]    neg_llr;
    logic [MW-1:0]   in_mag;
    logic [MW-1:0]   sel_mag;
    logic [MW-1:0]   adj_mag;
    logic [W-1:0]    mag_ext;
    logic            out_sign;

    assign emit     = (state_q == StEmit);
    assign in_ready = ~emit;
    assign accept   = in_valid & in_ready;
    assign cnt_last = (cnt_q == CW'(DEG - 1));

    // Saturating sign-magnitude conversion; only -2^(W-1) negates back to a negative value
    always_comb begin
        neg_llr = -in_llr;
        if (!in_llr[W-1]) begin
            in_mag = in_llr[MW-1:0];
        end else if (neg_llr[W-1]) begin
            in_mag = MagMax;
        end else begin
            in_mag = neg_llr[MW-1:0];
        end
    end

    // Next-state logic for the FSM and the row accumulators
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        min1_d   = min1_q;
        min2_d   = min2_q;
        idx1_d   = idx1_q;
        signs_d  = signs_q;
        parity_d = parity_q;
        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    signs_d[cnt_q] = in_llr[W-1];
                    parity_d       = parity_q ^ in_llr[W-1];
                    // Strict compares: a tie with min1 lands in min2
                    if (in_mag < min1_q) begin
                        min2_d = min1_q;
                        min1_d = in_mag;
                        idx1_d = cnt_q;
                    end else if (in_mag < min2_q) begin
                        min2_d = in_mag;
                    end
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = StEmit;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StEmit: begin
                if (out_ready) begin
                    if (cnt_last) begin
                        state_d  = StCollect;
                        cnt_d    = '0;
                        min1_d   = MagMax;
                        min2_d   = MagMax;
                        idx1_d   = '0;
                        parity_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StCollect;
        endcase
    end

    // State registers; reset discards any partial row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StCollect;
            cnt_q    <= '0;
            min1_q   <= MagMax;
            min2_q   <= MagMax;
            idx1_q   <= '0;
            signs_q  <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            min1_q   <= min1_d;
            min2_q   <= min2_d;
            idx1_q   <= idx1_d;
            signs_q  <= signs_d;
            parity_q <= parity_d;
        end
    end

    // Output datapath: depends on registers only, never on out_ready
    always_comb begin
        sel_mag = (cnt_q == idx1_q) ? min2_q : min1_q;
`ifdef CNU_OFFSET_EN
        adj_mag = (sel_mag > MW'(BETA)) ? (sel_mag - MW'(BETA)) : '0;
`else
        adj_mag = sel_mag;
`endif
        out_sign  = parity_q ^ signs_q[cnt_q];
        mag_ext   = {1'b0, adj_mag};
        out_valid = emit;
        out_last  = emit & cnt_last;
        busy      = emit | (cnt_q != '0);
        // Negating a zero magnitude yields 0, so -0 never appears
        if (!emit) begin
            out_llr = '0;
        end else if (out_sign) begin
            out_llr = -mag_ext;
        end else begin
            out_llr = mag_ext;
        end
    end

endmodule

// File: tb/tb_cnu_minsum_seq.sv
// Self-checking bench for cnu_minsum_seq (W=10, DEG=4).
// Expected C2V values come from an exclusion-min model: for output j, the
// magnitude is the minimum |x_i| over i != j and the sign is the XOR of the others.
module tb_cnu_minsum_seq;

    localparam int W    = 10;
    localparam int DEG  = 4;
    localparam int BETA = 1;

    typedef int row_t[DEG];

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_llr = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_llr;
    logic         out_last;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_llr[$];
    bit exp_last[$];

    cnu_minsum_seq #(
        .W    (W),
        .DEG  (DEG),
        .BETA (BETA)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_llr    (in_llr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_llr   (out_llr),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
    endtask

    // Exclusion-min reference for output j of a row
    function automatic int model_out(input row_t v, input int j);
        int m;
        int a;
        bit s;
        m = 1 << 20;
        s = 1'b0;
        for (int i = 0; i < DEG; i++) begin
            if (i != j) begin
                a = (v[i] < 0) ? -v[i] : v[i];
                if (a > 511) a = 511;
                if (a < m) m = a;
                s ^= (v[i] < 0);
            end
        end
`ifdef CNU_OFFSET_EN
        m = (m > BETA) ? m - BETA : 0;
`endif
        return s ? -m : m;
    endfunction

    // Compare process: every cycle an output is presented
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            check("in_ready_in_emit", int'(in_ready), 0);
            if (exp_llr.size() == 0) begin
                fail_now("unexpected_output");
            end else begin
                check("out_llr", int'($signed(out_llr)), exp_llr[0]);
                check("out_last", int'(out_last), int'(exp_last[0]));
                if (out_ready) begin
                    void'(exp_llr.pop_front());
                    void'(exp_last.pop_front());
                end
            end
        end
    end

    task automatic send_row(input row_t v);
        bit ok;
        for (int j = 0; j < DEG; j++) begin
            exp_llr.push_back(model_out(v, j));
            exp_last.push_back(j == DEG - 1);
        end
        for (int k = 0; k < DEG; k++) begin
            in_valid = 1'b1;
            in_llr   = W'(v[k]);
            ok = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                fail_now("input_accept");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (k == 0) check("busy_partial_row", int'(busy), 1);
            if (k == DEG - 1) check("first_out_latency", int'(out_valid), 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) fail_now("wait_out_valid");
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk);
            #1;
            if (exp_llr.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        out_ready = 1'b0;
        if (!ok) fail_now("drain");
        check("in_ready_after_row", int'(in_ready), 1);
        check("busy_after_row", int'(busy), 0);
        check("out_valid_after_row", int'(out_valid), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_llr"}, int'(out_llr), 0);
        check({tag, "_out_last"}, int'(out_last), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t c1;
        row_t c2;
        row_t c3;
        row_t c5;
        int   hold_exp;
        c1 = '{5, -3, 7, -8};
        c2 = '{-512, -512, -512, -512};
        c3 = '{4, 4, 9, 9};
        c5 = '{1, 2, 3, 4};

        // Reset state
        #12;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pin the model with hand-computed values
`ifdef CNU_OFFSET_EN
        check("model_c1_j0", model_out(c1, 0), 2);
        check("model_c1_j1", model_out(c1, 1), -4);
        check("model_c1_j2", model_out(c1, 2), 2);
        check("model_c1_j3", model_out(c1, 3), -2);
        check("model_c5_j0", model_out(c5, 0), 1);
        hold_exp = -4;
`else
        check("model_c1_j0", model_out(c1, 0), 3);
        check("model_c1_j1", model_out(c1, 1), -5);
        check("model_c1_j2", model_out(c1, 2), 3);
        check("model_c1_j3", model_out(c1, 3), -3);
        check("model_c2_j0", model_out(c2, 0), -511);
        check("model_c3_j0", model_out(c3, 0), 4);
        check("model_c5_j0", model_out(c5, 0), 2);
        check("model_c5_j1", model_out(c5, 1), 1);
        hold_exp = -5;
`endif

        // 1: basic row
        send_row(c1);
        wait_valid();
        drain();

        // 2: saturation of -512
        send_row(c2);
        wait_valid();
        drain();

        // 3: ties
        send_row(c3);
        wait_valid();
        drain();

        // 4: back-pressure at j=1
        send_row(c1);
        wait_valid();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("hold_out_llr", int'($signed(out_llr)), hold_exp);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_out_valid", int'(out_valid), 1);
        end
        drain();

        // 5: reset in EMIT at j=2
        send_row(c1);
        wait_valid();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_emit_reset");
        exp_llr.delete();
        exp_last.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_out_valid", int'(out_valid), 0);
        send_row(c5);
        wait_valid();
        drain();

`ifdef CNU_OFFSET_EN
        // 6: offset floor, zero never negative
        begin
            row_t c6;
            c6 = '{1, -1, 6, 6};
            for (int j = 0; j < DEG; j++) check("model_c6", model_out(c6, j), 0);
            send_row(c6);
            wait_valid();
            drain();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
